// File: rtl/usb_pkg.sv
// Shared definitions for the USB-style transmitter: FSM state encoding and CRC-16/USB constants.
// Also provides the single-bit reflected CRC step used by the byte-wide CRC stage.
package usb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        CRC1 = 2'b10,
        CRC2 = 2'b11
    } tx_state_e;

    localparam logic [15:0] CRC16_POLY_REF = 16'hA001;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;

    // One reflected CRC step: feedback is the register LSB xor the incoming bit.
    function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic bit_in);
        logic [15:0] shifted;
        shifted = {1'b0, crc[15:1]};
        return (crc[0] ^ bit_in) ? (shifted ^ CRC16_POLY_REF) : shifted;
    endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// Combinational CRC-16/USB update for one full byte, bits consumed LSB first.
module usb_crc16_byte
    import usb_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_acc_s;

    // Unrolled eight-step bit-serial update
    always_comb begin
        crc_acc_s = crc_in;
        for (int i = 0; i < 8; i++) begin
            crc_acc_s = crc16_bit(crc_acc_s, data_in[i]);
        end
    end

    assign crc_out = crc_acc_s;

endmodule

// File: rtl/usb_tx_crc_fsm.sv
// Packet transmitter: forwards a payload over valid/ready and appends a CRC-16/USB trailer, LSB first.
// Optional macro USB_TX_ABORT_EN adds an abort input that drops the packet in progress.
module usb_tx_crc_fsm
    import usb_pkg::*;
#(
    parameter int MAX_LEN    = 64,
    parameter int LEN_W      = $clog2(MAX_LEN + 1),
    parameter int HIST_DEPTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef USB_TX_ABORT_EN
    input  logic                  abort,
`endif
    input  logic                  send_data,
    input  logic [LEN_W-1:0]      pkt_len,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_last,
    output logic                  busy,
    output logic [HIST_DEPTH-1:0] buff
);

    tx_state_e             state_r, state_nxt_s;
    logic [LEN_W-1:0]      cnt_r, cnt_nxt_s;
    logic [LEN_W-1:0]      len_r, len_nxt_s;
    logic [15:0]           crc_r, crc_nxt_s, crc_upd_s;
    logic [HIST_DEPTH-1:0] buff_r;
    logic [LEN_W-1:0]      len_clamp_s;
    logic                  last_beat_s, fire_s, abort_s;
    logic [7:0]            tx_data_s;
    logic                  tx_valid_s, in_ready_s, tx_last_s;

`ifdef USB_TX_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign len_clamp_s = (pkt_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pkt_len;
    assign last_beat_s = (cnt_r == (len_r - LEN_W'(1)));

    usb_crc16_byte u_crc (
        .crc_in  (crc_r),
        .data_in (in_data),
        .crc_out (crc_upd_s)
    );

    // Handshake and data outputs decoded from the current state
    always_comb begin
        tx_data_s  = 8'h00;
        tx_valid_s = 1'b0;
        in_ready_s = 1'b0;
        tx_last_s  = 1'b0;
        case (state_r)
            IDLE: begin
                tx_valid_s = 1'b0;
            end
            DATA: begin
                tx_data_s  = in_data;
                tx_valid_s = in_valid;
                in_ready_s = tx_ready;
            end
            CRC1: begin
                tx_data_s  = ~crc_r[7:0];
                tx_valid_s = 1'b1;
            end
            CRC2: begin
                tx_data_s  = ~crc_r[15:8];
                tx_valid_s = 1'b1;
                tx_last_s  = 1'b1;
            end
            default: begin
                tx_valid_s = 1'b0;
            end
        endcase
    end

    // An abort cycle must never complete a transfer on either side
    assign tx_data  = tx_data_s;
    assign tx_valid = tx_valid_s & ~abort_s;
    assign in_ready = in_ready_s & ~abort_s;
    assign tx_last  = tx_last_s;
    assign fire_s   = tx_valid & tx_ready;
    assign busy     = (state_r != IDLE);
    assign buff     = buff_r;

    // Next-state, counter and CRC update
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        len_nxt_s   = len_r;
        crc_nxt_s   = crc_r;
        if (abort_s && (state_r != IDLE)) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {LEN_W{1'b0}};
            crc_nxt_s   = CRC16_INIT;
        end else begin
            case (state_r)
                IDLE: begin
                    if (send_data) begin
                        len_nxt_s   = len_clamp_s;
                        cnt_nxt_s   = {LEN_W{1'b0}};
                        crc_nxt_s   = CRC16_INIT;
                        state_nxt_s = (len_clamp_s != {LEN_W{1'b0}}) ? DATA : CRC1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                DATA: begin
                    if (fire_s) begin
                        crc_nxt_s   = crc_upd_s;
                        cnt_nxt_s   = cnt_r + LEN_W'(1);
                        state_nxt_s = last_beat_s ? CRC1 : DATA;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end
                CRC1: begin
                    if (fire_s) begin
                        state_nxt_s = CRC2;
                    end else begin
                        state_nxt_s = CRC1;
                    end
                end
                CRC2: begin
                    if (fire_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = CRC2;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State, counter, CRC and fire-history registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= {LEN_W{1'b0}};
            len_r   <= {LEN_W{1'b0}};
            crc_r   <= CRC16_INIT;
            buff_r  <= {HIST_DEPTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            len_r   <= len_nxt_s;
            crc_r   <= crc_nxt_s;
            buff_r  <= {buff_r[HIST_DEPTH-2:0], fire_s};
        end
    end

endmodule

// File: tb/tb_usb_tx_crc_fsm.sv
// Self-checking bench for usb_tx_crc_fsm: a byte-stream scoreboard built from a message-level
// CRC-16/USB model, plus literal expectations for reset, history register and abandonment cases.
module tb_usb_tx_crc_fsm;

    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 7;
    localparam int HD      = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             send_data;
    logic [LEN_W-1:0] pkt_len;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_last;
    logic             busy;
    logic [HD-1:0]    buff;
    logic             abort_now;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pay[70];
    logic       in_ready_seen;

    always #5 clk = ~clk;

`ifdef USB_TX_ABORT_EN
    logic abort;
    assign abort_now = abort;
`else
    assign abort_now = 1'b0;
`endif

    usb_tx_crc_fsm #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .HIST_DEPTH(HD)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef USB_TX_ABORT_EN
        .abort     (abort),
`endif
        .send_data (send_data),
        .pkt_len   (pkt_len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_last   (tx_last),
        .busy      (busy),
        .buff      (buff)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Whole-message CRC-16/USB as a receiver would compute it (final xor applied).
    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, pay[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
            end
        end
        return c ^ 16'hFFFF;
    endfunction

    // Scoreboard and stall-stability monitor, sampled on the falling edge
    logic [7:0] p_data;
    logic       p_last, p_stall = 1'b0;
    always @(negedge clk) begin
        logic [7:0] e;
        if (reset === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fire actual=%0h required=no_transfer", tx_data);
            end else begin
                e = exp_q.pop_front();
                check("tx_data", {24'h0, tx_data}, {24'h0, e});
                check("tx_last", {31'h0, tx_last}, (exp_q.size() == 0) ? 32'd1 : 32'd0);
            end
        end
        if (p_stall && reset === 1'b1 && abort_now !== 1'b1)
            check("stall_hold", {22'h0, tx_valid, tx_last, tx_data}, {22'h0, 1'b1, p_last, p_data});
        p_stall = (reset === 1'b1) && (tx_valid === 1'b1) && (tx_ready === 1'b0) && (abort_now !== 1'b1);
        p_data  = tx_data;
        p_last  = tx_last;
        if (in_ready === 1'b1) in_ready_seen = 1'b1;
    end

    // mode 0: complete; mode 1: reset while in CRC1; mode 2: abort after 3 bytes
    task automatic run_pkt(input int len_in, input int n_offer, input bit toggle, input bit noise, input int mode);
        int n, idx, cyc;
        bit done, acc, fin;
        logic [15:0] cr;
        n  = (len_in > MAX_LEN) ? MAX_LEN : len_in;
        cr = crc_model(n);
        for (int i = 0; i < n; i++) exp_q.push_back(pay[i]);
        exp_q.push_back(cr[7:0]);
        exp_q.push_back(cr[15:8]);
        @(posedge clk); #1;
        send_data = 1'b1; pkt_len = LEN_W'(len_in); in_valid = 1'b0; tx_ready = 1'b1;
        @(posedge clk); #1;
        send_data = noise;
        idx = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 400) begin
            in_valid = (idx < n_offer);
            in_data  = (idx < n_offer) ? pay[idx] : 8'h00;
            tx_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            acc = in_valid & in_ready;
            fin = tx_valid & tx_ready & tx_last;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
            done = fin;
            if (mode == 1 && idx == n) begin
                send_data = 1'b0; tx_ready = 1'b0; in_valid = 1'b0;
                #1;
                check("crc1_valid", {31'h0, tx_valid}, 32'd1);
                check("crc1_lo", {24'h0, tx_data}, 32'hC8);
                reset = 1'b0;
                exp_q.delete();
                @(posedge clk); #1;
                reset = 1'b1;
                check("rst_busy", {31'h0, busy}, 32'd0);
                check("rst_valid", {31'h0, tx_valid}, 32'd0);
                return;
            end
`ifdef USB_TX_ABORT_EN
            if (mode == 2 && idx == 3) begin
                abort = 1'b1;
                exp_q.delete();
                #1;
                check("abort_valid", {31'h0, tx_valid}, 32'd0);
                check("abort_ready", {31'h0, in_ready}, 32'd0);
                @(posedge clk); #1;
                abort = 1'b0; send_data = 1'b0; in_valid = 1'b0;
                check("abort_busy", {31'h0, busy}, 32'd0);
                return;
            end
`endif
        end
        send_data = 1'b0;
        in_valid  = 1'b0;
        check("pkt_done", {31'h0, done}, 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);
        check("accepted", idx, n);
    endtask

    initial begin
        for (int i = 0; i < 70; i++) pay[i] = (i < 9) ? 8'(8'h31 + i) : 8'(i * 7 + 3);
        reset = 1'b0; send_data = 1'b1; pkt_len = LEN_W'(5); in_data = 8'h00;
        in_valid = 1'b0; tx_ready = 1'b0; in_ready_seen = 1'b0;
`ifdef USB_TX_ABORT_EN
        abort = 1'b0;
`endif
        check("model_pin_123456789", {16'h0, crc_model(9)}, 32'hB4C8);
        check("model_pin_empty", {16'h0, crc_model(0)}, 32'h0000);

        // 1: reset held with a start request pending
        repeat (3) begin
            @(negedge clk);
            check("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
            check("rst_in_ready", {31'h0, in_ready}, 32'd0);
            check("rst_busy0", {31'h0, busy}, 32'd0);
            check("rst_buff", {22'h0, buff}, 32'd0);
        end
        @(posedge clk); #1;
        send_data = 1'b0; reset = 1'b1;

        // 2: reference message at full rate
        run_pkt(9, 9, 1'b0, 1'b0, 0);
        check("buff_full_rate", {22'h0, buff}, 32'h3FF);

        // 3: empty payload
        in_ready_seen = 1'b0;
        run_pkt(0, 0, 1'b0, 1'b0, 0);
        check("len0_no_in_ready", {31'h0, in_ready_seen}, 32'd0);

        // 4: alternating back-pressure
        run_pkt(9, 9, 1'b1, 1'b0, 0);
        check("buff_alternate", {22'h0, buff}, 32'h155);

        // 5: oversize length clamps; start requests while busy are ignored
        run_pkt(70, 70, 1'b0, 1'b1, 0);
        repeat (3) @(negedge clk);
        check("noise_idle", {31'h0, busy}, 32'd0);

        // 6: reset in CRC1 abandons the packet, then a clean packet follows
        run_pkt(9, 9, 1'b0, 1'b0, 1);
        repeat (4) @(negedge clk);
        check("after_rst_idle", {31'h0, busy}, 32'd0);
`ifdef USB_TX_ABORT_EN
        run_pkt(9, 9, 1'b0, 1'b0, 2);
        repeat (4) @(negedge clk);
        check("after_abort_idle", {31'h0, busy}, 32'd0);
`endif
        run_pkt(9, 9, 1'b0, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
